tlul_adapter_host_ordered: RTL and testbench

//  Host-side req/gnt/rvalid to TL-UL adapter with up to MaxReqs outstanding transactions.

---
 rtl/tlul_adapter_host_ordered_pkg.sv | 47 ++++
 rtl/tlul_adapter_host_ordered_rsp_reorder_buf.sv | 93 +++++++++
 rtl/tlul_adapter_host_ordered.sv | 69 ++++++
 tb/tb_tlul_adapter_host_ordered.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_adapter_host_ordered_pkg.sv
// tlul_adapter_host_ordered_pkg: TL-UL channel types and widths shared by the host adapter.
package tlul_adapter_host_ordered_pkg;
   localparam int TL_AW    = 32;
   localparam int TL_DW    = 32;
   localparam int TL_DBW   = TL_DW / 8;
   localparam int TL_AIW   = 8;
   localparam int TL_DIW   = 1;
   localparam int TL_SZW   = 2;
   localparam int WordSize = $clog2(TL_DBW);
   typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
   typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
   typedef logic [3:0] mubi4_t;
   localparam mubi4_t MuBi4True  = 4'h6;
   localparam mubi4_t MuBi4False = 4'h9;
   typedef struct packed {
      logic [4:0] rsvd;
      mubi4_t     instr_type;
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;
   typedef struct packed {
      logic              a_valid;
      tl_a_op_e          a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      tl_a_user_t        a_user;
      logic              d_ready;
   } tl_h2d_t;
   typedef struct packed {
      logic              d_valid;
      tl_d_op_e          d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic [TL_DIW-1:0] d_sink;
      logic [TL_DW-1:0]  d_data;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;
   function automatic int id_w(int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/tlul_adapter_host_ordered_rsp_reorder_buf.sv
// tlul_rsp_reorder_buf: per-tag response slots with head/tail/count, delivering in issue or arrival order.
module tlul_rsp_reorder_buf
   import tlul_adapter_host_ordered_pkg::*;
#(
   parameter int MaxReqs    = 4,
   parameter int RspInOrder = 1,
   localparam int IdW       = id_w(MaxReqs)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              issue_i,
   input  logic              rsp_valid_i,
   input  logic [TL_AIW-1:0] rsp_src_i,
   input  logic [TL_DW-1:0]  rsp_data_i,
   input  logic              rsp_err_i,
   output logic              full_o,
   output logic              accept_o,
   output logic [IdW-1:0]    tail_o,
   output logic              valid_o,
   output logic              err_o,
   output logic [TL_DW-1:0]  rdata_o,
   output logic [IdW-1:0]    rsp_id_o
);
   typedef struct packed {
      logic             busy;
      logic             filled;
      logic             err;
      logic [TL_DW-1:0] data;
   } rsp_slot_t;
   localparam int CntW = $clog2(MaxReqs + 1);
   localparam bit InOrder = RspInOrder != 0;
   rsp_slot_t [MaxReqs-1:0] slots_q, slots_d;
   logic [IdW-1:0] head_q, head_d, tail_q, tail_d, src, did;
   logic [CntW-1:0] count_q, count_d;
   logic hit, deliver, dat_err, valid_q, err_q;
   logic [TL_DW-1:0] dat, rdata_q;
   logic [IdW-1:0] rsp_id_q;
   function automatic logic [IdW-1:0] wrap_inc(logic [IdW-1:0] i);
      return (i == IdW'(MaxReqs - 1)) ? '0 : i + 1'b1;
   endfunction
   assign src      = rsp_src_i[IdW-1:0];
   assign accept_o = rsp_valid_i & (rsp_src_i < TL_AIW'(MaxReqs)) & slots_q[src].busy & ~slots_q[src].filled;
   assign hit      = accept_o & (src == head_q);
   assign deliver  = InOrder ? (slots_q[head_q].filled | hit) : accept_o;
   assign did      = InOrder ? head_q : src;
   assign dat      = (InOrder & ~hit) ? slots_q[head_q].data : rsp_data_i;
   assign dat_err  = (InOrder & ~hit) ? slots_q[head_q].err : rsp_err_i;
   // A busy tail slot only happens out of order (or when full), so it doubles as back-pressure.
   assign full_o   = (count_q == CntW'(MaxReqs)) | slots_q[tail_q].busy;
   assign tail_o   = tail_q;
   always_comb begin
      slots_d = slots_q;
      if (issue_i) slots_d[tail_q].busy = 1'b1;
      if (accept_o) begin
         slots_d[src].filled = 1'b1;
         slots_d[src].err    = rsp_err_i;
         slots_d[src].data   = rsp_data_i;
      end
      if (deliver) slots_d[did] = '0;
      tail_d  = (issue_i | (~InOrder & slots_q[tail_q].busy)) ? wrap_inc(tail_q) : tail_q;
      head_d  = (InOrder & deliver) ? wrap_inc(head_q) : head_q;
      count_d = count_q + CntW'(issue_i) - CntW'(deliver);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slots_q  <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         rsp_id_q <= '0;
      end else begin
         slots_q <= slots_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= deliver;
         if (deliver) begin
            err_q    <= dat_err;
            rdata_q  <= dat;
            rsp_id_q <= did;
         end
      end
   end
   assign valid_o  = valid_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;
   assign rsp_id_o = rsp_id_q;
   a_count_max: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CntW'(MaxReqs));
   a_deliver_issued: assert property (@(posedge clk_i) disable iff (rst_i) deliver |-> count_q != '0);
endmodule

// File: rtl/tlul_adapter_host_ordered.sv
// tlul_adapter_host_ordered: req/gnt host port to TL-UL with credit-limited outstanding requests
// and optional in-order response delivery.
module tlul_adapter_host_ordered
   import tlul_adapter_host_ordered_pkg::*;
#(
   parameter int MaxReqs    = 4,
   parameter int RspInOrder = 1,
   localparam int IdW       = id_w(MaxReqs)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic [TL_AW-1:0]  addr_i,
   input  logic              we_i,
   input  logic [TL_DW-1:0]  wdata_i,
   input  logic [TL_DBW-1:0] be_i,
   input  mubi4_t            instr_type_i,
   output logic [IdW-1:0]    req_id_o,
   output logic              valid_o,
   output logic [TL_DW-1:0]  rdata_o,
   output logic              err_o,
   output logic [IdW-1:0]    rsp_id_o,
   output logic              proto_err_o,
   output tl_h2d_t           tl_o,
   input  tl_d2h_t           tl_i
);
   logic full, accept, proto_err_q;
   logic [IdW-1:0] tail;
   logic unused_d;
   assign gnt_o    = tl_i.a_ready & ~full;
   assign req_id_o = tail;
   assign unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink};
   always_comb begin
      tl_o                   = '0;
      tl_o.a_valid           = req_i & ~full;
      tl_o.a_opcode          = we_i ? (&be_i ? PutFullData : PutPartialData) : Get;
      tl_o.a_size            = TL_SZW'(WordSize);
      tl_o.a_source          = TL_AIW'(tail);
      tl_o.a_address         = addr_i & ~TL_AW'(TL_DBW - 1);
      tl_o.a_mask            = we_i ? be_i : '1;
      tl_o.a_data            = wdata_i;
      tl_o.a_user.instr_type = instr_type_i;
      tl_o.d_ready           = 1'b1;
   end
   tlul_rsp_reorder_buf #(.MaxReqs(MaxReqs), .RspInOrder(RspInOrder)) u_rob (
      .clk_i,
      .rst_i,
      .issue_i     (req_i & gnt_o),
      .rsp_valid_i (tl_i.d_valid),
      .rsp_src_i   (tl_i.d_source),
      .rsp_data_i  (tl_i.d_data),
      .rsp_err_i   (tl_i.d_error),
      .full_o      (full),
      .accept_o    (accept),
      .tail_o      (tail),
      .valid_o,
      .err_o,
      .rdata_o,
      .rsp_id_o
   );
   // Sticky until reset: any response without a live, unfilled slot.
   always_ff @(posedge clk_i) begin
      if (rst_i) proto_err_q <= 1'b0;
      else if (tl_i.d_valid & ~accept) proto_err_q <= 1'b1;
   end
   assign proto_err_o = proto_err_q;
   a_valid_stable: assert property (@(posedge clk_i) disable iff (rst_i) tl_o.a_valid & ~tl_i.a_ready |=> tl_o.a_valid);
endmodule

// File: tb/tb_tlul_adapter_host_ordered.sv
// tb_tlul_adapter_host_ordered: directed scenarios plus randomized traffic against a queue-based model.
module tb_tlul_adapter_host_ordered;
   import tlul_adapter_host_ordered_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic req, we;
   logic [31:0] addr, wdata;
   logic [3:0] be;
   mubi4_t instr;
   tl_d2h_t tl_d;
   logic gnt, valid, err, proto, gnt0, valid0, err0, proto0;
   logic [1:0] req_id, rsp_id, req_id0, rsp_id0;
   logic [31:0] rdata, rdata0;
   tl_h2d_t tl_a, tl_a0;
   int checks = 0, errors = 0;

   tlul_adapter_host_ordered #(.MaxReqs(4), .RspInOrder(1)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
      .wdata_i(wdata), .be_i(be), .instr_type_i(instr), .req_id_o(req_id), .valid_o(valid),
      .rdata_o(rdata), .err_o(err), .rsp_id_o(rsp_id), .proto_err_o(proto), .tl_o(tl_a), .tl_i(tl_d));
   tlul_adapter_host_ordered #(.MaxReqs(4), .RspInOrder(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt0), .addr_i(addr), .we_i(we),
      .wdata_i(wdata), .be_i(be), .instr_type_i(instr), .req_id_o(req_id0), .valid_o(valid0),
      .rdata_o(rdata0), .err_o(err0), .rsp_id_o(rsp_id0), .proto_err_o(proto0), .tl_o(tl_a0), .tl_i(tl_d));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 0; we = 0; addr = '0; wdata = '0; be = '0; instr = MuBi4False;
      tl_d = '0;
      tl_d.a_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic rsp(input logic [7:0] src, input logic [31:0] d, input logic e);
      tl_d.d_valid = 1'b1; tl_d.d_opcode = AccessAckData; tl_d.d_source = src;
      tl_d.d_data = d; tl_d.d_error = e;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (proto !== 1'b0) begin errors++; $display("FAIL reset_proto got=%b exp=0", proto); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
      checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got=%b exp=1", gnt); end
      checks++; if (req_id !== 2'd0) begin errors++; $display("FAIL reset_req_id got=%0d exp=0", req_id); end
   endtask

   task automatic test_single_read();
      do_reset();
      req = 1; addr = 32'h40;
      #1;
      checks++; if (gnt !== 1'b1 || req_id !== 2'd0) begin errors++; $display("FAIL single_issue got gnt=%b id=%0d exp gnt=1 id=0", gnt, req_id); end
      tick();
      req = 0;
      tick(); tick(); tick();
      rsp(8'd0, 32'hDEAD_BEEF, 1'b0);
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", valid); end
      tick();
      tl_d.d_valid = 0;
      checks++; if (valid !== 1'b1 || rdata !== 32'hDEAD_BEEF || rsp_id !== 2'd0 || err !== 1'b0)
         begin errors++; $display("FAIL single_rsp got v=%b d=%h id=%0d e=%b exp v=1 d=deadbeef id=0 e=0", valid, rdata, rsp_id, err); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b exp=0", valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      req = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (gnt !== (i < 4)) begin errors++; $display("FAIL b2b_gnt%0d got=%b exp=%b", i, gnt, i < 4); end
         if (i < 4) begin
            checks++; if (req_id !== 2'(i)) begin errors++; $display("FAIL b2b_tag%0d got=%0d exp=%0d", i, req_id, i); end
         end
         tick();
      end
      rsp(8'd0, 32'h1234_5678, 1'b0);
      #1;
      checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL b2b_held got=%b exp=0", gnt); end
      tick();
      tl_d.d_valid = 0;
      checks++; if (valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL b2b_deliver got v=%b id=%0d exp v=1 id=0", valid, rsp_id); end
      #1;
      checks++; if (gnt !== 1'b1 || req_id !== 2'd0) begin errors++; $display("FAIL b2b_regrant got gnt=%b id=%0d exp gnt=1 id=0", gnt, req_id); end
      tick();
      req = 0;
   endtask

   task automatic test_order();
      int ord[3] = '{2, 0, 1};
      logic [31:0] d[3];
      int ex_v[6] = '{0, 1, 1, 1, 0, 0};
      int ex_id[6] = '{0, 0, 1, 2, 0, 0};
      int ex0_v[6] = '{1, 1, 1, 0, 0, 0};
      int ex0_id[6] = '{2, 0, 1, 0, 0, 0};
      do_reset();
      for (int i = 0; i < 3; i++) d[i] = $urandom;
      req = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (req_id !== 2'(i) || req_id0 !== 2'(i)) begin errors++; $display("FAIL order_tag%0d got=%0d/%0d exp=%0d", i, req_id, req_id0, i); end
         tick();
      end
      req = 0;
      for (int k = 0; k < 6; k++) begin
         if (k < 3) rsp(8'(ord[k]), d[ord[k]], 1'b0);
         else tl_d.d_valid = 0;
         tick();
         checks++;
         if (valid !== 1'(ex_v[k]) || (ex_v[k] != 0 && (rsp_id !== 2'(ex_id[k]) || rdata !== d[ex_id[k]])))
            begin errors++; $display("FAIL inorder_c%0d got v=%b id=%0d d=%h exp v=%0d id=%0d d=%h", k, valid, rsp_id, rdata, ex_v[k], ex_id[k], d[ex_id[k]]); end
         checks++;
         if (valid0 !== 1'(ex0_v[k]) || (ex0_v[k] != 0 && (rsp_id0 !== 2'(ex0_id[k]) || rdata0 !== d[ex0_id[k]])))
            begin errors++; $display("FAIL arrival_c%0d got v=%b id=%0d d=%h exp v=%0d id=%0d d=%h", k, valid0, rsp_id0, rdata0, ex0_v[k], ex0_id[k], d[ex0_id[k]]); end
      end
   endtask

   task automatic test_proto_err();
      do_reset();
      rsp(8'd3, 32'hBAD0_0003, 1'b0);
      tick();
      tl_d.d_valid = 0;
      checks++; if (valid !== 1'b0 || proto !== 1'b1) begin errors++; $display("FAIL proto_idle got v=%b p=%b exp v=0 p=1", valid, proto); end
      tick(); tick();
      checks++; if (proto !== 1'b1) begin errors++; $display("FAIL proto_hold got=%b exp=1", proto); end
      do_reset();
      req = 1;
      tick();
      req = 0;
      rsp(8'd0, 32'h0000_00A0, 1'b1);
      tick();
      checks++; if (valid !== 1'b1 || err !== 1'b1 || proto !== 1'b0) begin errors++; $display("FAIL proto_first got v=%b e=%b p=%b exp v=1 e=1 p=0", valid, err, proto); end
      tick();
      tl_d.d_valid = 0;
      checks++; if (valid !== 1'b0 || proto !== 1'b1) begin errors++; $display("FAIL proto_dup got v=%b p=%b exp v=0 p=1", valid, proto); end
      do_reset();
      req = 1;
      tick(); tick();
      req = 0;
      rsp(8'd1, 32'h1111_1111, 1'b0);
      tick();
      rsp(8'd1, 32'h2222_2222, 1'b0);
      tick();
      tl_d.d_valid = 0;
      checks++; if (valid !== 1'b0 || proto !== 1'b1) begin errors++; $display("FAIL proto_dup_filled got v=%b p=%b exp v=0 p=1", valid, proto); end
      rsp(8'd0, 32'h0000_0000, 1'b0);
      tick();
      tl_d.d_valid = 0;
      tick();
      checks++; if (valid !== 1'b1 || rsp_id !== 2'd1 || rdata !== 32'h1111_1111) begin errors++; $display("FAIL proto_kept got v=%b id=%0d d=%h exp v=1 id=1 d=11111111", valid, rsp_id, rdata); end
   endtask

   task automatic test_write_map();
      do_reset();
      req = 1; we = 1; addr = 32'h1003; be = 4'b0011; wdata = $urandom; instr = MuBi4True;
      #1;
      checks++; if (tl_a.a_opcode !== PutPartialData || tl_a.a_address !== 32'h1000 || tl_a.a_mask !== 4'b0011)
         begin errors++; $display("FAIL wr_partial got op=%0d a=%h m=%b exp op=1 a=1000 m=0011", tl_a.a_opcode, tl_a.a_address, tl_a.a_mask); end
      checks++; if (tl_a.a_data !== wdata || tl_a.a_size !== 2'd2 || tl_a.a_user.instr_type !== MuBi4True || tl_a.a_source !== 8'd0)
         begin errors++; $display("FAIL wr_fields got d=%h sz=%0d it=%h src=%0d exp d=%h sz=2 it=6 src=0", tl_a.a_data, tl_a.a_size, tl_a.a_user.instr_type, tl_a.a_source, wdata); end
      checks++; if (tl_a.a_valid !== 1'b1 || tl_a.d_ready !== 1'b1 || tl_a.a_param !== 3'd0)
         begin errors++; $display("FAIL wr_ctl got av=%b dr=%b p=%0d exp av=1 dr=1 p=0", tl_a.a_valid, tl_a.d_ready, tl_a.a_param); end
      be = 4'hF;
      #1;
      checks++; if (tl_a.a_opcode !== PutFullData || tl_a.a_mask !== 4'hF) begin errors++; $display("FAIL wr_full got op=%0d m=%b exp op=0 m=1111", tl_a.a_opcode, tl_a.a_mask); end
      we = 0; be = 4'h0;
      #1;
      checks++; if (tl_a.a_opcode !== Get || tl_a.a_mask !== 4'hF) begin errors++; $display("FAIL rd_get got op=%0d m=%b exp op=4 m=1111", tl_a.a_opcode, tl_a.a_mask); end
      tl_d.a_ready = 0;
      #1;
      checks++; if (gnt !== 1'b0 || tl_a.a_valid !== 1'b1) begin errors++; $display("FAIL rd_noready got gnt=%b av=%b exp gnt=0 av=1", gnt, tl_a.a_valid); end
      tl_d.a_ready = 1; req = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 1;
      tick(); tick();
      req = 0;
      rst = 1;
      tick();
      rst = 0;
      rsp(8'd1, 32'hCAFE_0001, 1'b0);
      tick();
      tl_d.d_valid = 0;
      checks++; if (valid !== 1'b0 || proto !== 1'b1) begin errors++; $display("FAIL rstmid_late got v=%b p=%b exp v=0 p=1", valid, proto); end
      req = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (gnt !== 1'b1 || req_id !== 2'(i)) begin errors++; $display("FAIL rstmid_credit%0d got gnt=%b id=%0d exp gnt=1 id=%0d", i, gnt, req_id, i); end
         tick();
      end
      #1;
      checks++; if (gnt !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_full got gnt=%b v=%b exp gnt=0 v=0", gnt, valid); end
      req = 0;
   endtask

   task automatic test_random();
      int q[$];
      bit pend[4], arrived[4];
      logic [31:0] adata[4];
      logic aerr[4];
      int tail_m = 0, t, cand[$];
      bit exp_gnt, exp_v;
      int exp_id;
      logic [31:0] exp_d;
      logic exp_e;
      do_reset();
      for (int i = 0; i < 4; i++) begin pend[i] = 0; arrived[i] = 0; end
      for (int c = 0; c < 400; c++) begin
         if (!req) begin
            req = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom; be = 4'($urandom);
         end
         tl_d.a_ready = $urandom_range(0, 3) != 0;
         cand.delete();
         for (int i = 0; i < 4; i++) if (pend[i]) cand.push_back(i);
         tl_d.d_valid = 0;
         if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            t = cand[$urandom_range(0, cand.size() - 1)];
            rsp(8'(t), $urandom, 1'($urandom_range(0, 1)));
            pend[t] = 0; arrived[t] = 1; adata[t] = tl_d.d_data; aerr[t] = tl_d.d_error;
         end
         #1;
         exp_gnt = tl_d.a_ready && q.size() < 4;
         checks++; if (gnt !== exp_gnt || req_id !== 2'(tail_m)) begin errors++; $display("FAIL rnd_gnt c%0d got gnt=%b id=%0d exp gnt=%b id=%0d", c, gnt, req_id, exp_gnt, tail_m); end
         exp_v = q.size() > 0 && arrived[q[0]];
         exp_id = 0; exp_d = '0; exp_e = 0;
         if (exp_v) begin
            exp_id = q.pop_front();
            exp_d = adata[exp_id]; exp_e = aerr[exp_id]; arrived[exp_id] = 0;
         end
         if (req && exp_gnt) begin
            q.push_back(tail_m); pend[tail_m] = 1; tail_m = (tail_m + 1) % 4;
         end
         tick();
         if (req && exp_gnt) req = 0;
         checks++;
         if (valid !== exp_v || (exp_v && (rsp_id !== 2'(exp_id) || rdata !== exp_d || err !== exp_e)))
            begin errors++; $display("FAIL rnd_rsp c%0d got v=%b id=%0d d=%h e=%b exp v=%b id=%0d d=%h e=%b", c, valid, rsp_id, rdata, err, exp_v, exp_id, exp_d, exp_e); end
      end
      tl_d.d_valid = 0;
      req = 0;
      checks++; if (proto !== 1'b0) begin errors++; $display("FAIL rnd_proto got=%b exp=0", proto); end
   endtask

   initial begin
      idle();
      test_reset();
      test_single_read();
      test_back_to_back();
      test_order();
      test_proto_err();
      test_write_map();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
